// File: rtl/velocidade_pkg.sv
// Shared speed-level type and speed codes, used by the selector and by the
// speed digit decoder that displays {A,B}.
package velocidade_pkg;

  typedef logic [1:0] speed_t;

  localparam speed_t SPD_STOP = 2'b00;
  localparam speed_t SPD_LOW  = 2'b01;
  localparam speed_t SPD_MID  = 2'b10;
  localparam speed_t SPD_HIGH = 2'b11;

endpackage

// File: rtl/debouncer.sv
// One button channel: 2-flop synchronizer, stable-count debouncer and a
// registered rising-edge pulse of the debounced level.
module debouncer #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic rise
);

  localparam logic [7:0] CNT_LAST = 8'(DEB_CYCLES - 1);

  logic       sync1;
  logic       sync2;
  logic       level;
  logic       level_prev;
  logic [7:0] cnt;

  // A single agreeing sample restarts the count, so only an unbroken run of
  // DEB_CYCLES disagreeing samples moves the debounced level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level      <= 1'b0;
      level_prev <= 1'b0;
      cnt        <= 8'd0;
      rise       <= 1'b0;
    end else begin
      sync1      <= raw;
      sync2      <= sync1;
      level_prev <= level;
      rise       <= level & ~level_prev;
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= 8'd0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end else begin
        cnt <= 8'd0;
      end
    end
  end

endmodule

// File: rtl/seletor_velocidade.sv
// Speed selector: debounced up/down buttons step a 2-bit speed level on {A,B}.
// Optional macro SPEED_WRAP_EN makes the level wrap at the ends instead of saturating.
module seletor_velocidade
  import velocidade_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_up,
  input  logic btn_down,
  output logic A,
  output logic B,
  output logic changed
);

  logic   up_rise;
  logic   down_rise;
  speed_t speed;
  speed_t speed_next;

  debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_up),
    .rise  (up_rise)
  );

  debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_down),
    .rise  (down_rise)
  );

  // Simultaneous up and down presses cancel out.
  always_comb begin
    speed_next = speed;
    if (up_rise && !down_rise) begin
      if (speed == SPD_HIGH) begin
`ifdef SPEED_WRAP_EN
        speed_next = SPD_STOP;
`else
        speed_next = SPD_HIGH;
`endif
      end else begin
        speed_next = speed + 2'd1;
      end
    end else if (down_rise && !up_rise) begin
      if (speed == SPD_STOP) begin
`ifdef SPEED_WRAP_EN
        speed_next = SPD_HIGH;
`else
        speed_next = SPD_STOP;
`endif
      end else begin
        speed_next = speed - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed   <= SPD_STOP;
      changed <= 1'b0;
    end else begin
      speed   <= speed_next;
      changed <= (speed_next != speed);
    end
  end

  assign A = speed[1];
  assign B = speed[0];

endmodule

// File: tb/tb_seletor_velocidade.sv
// Scoreboard bench for seletor_velocidade: a sliding-window reference model
// predicts each speed step; a negedge monitor pops and compares.
module tb_seletor_velocidade;

  localparam int DEB = 4;
  localparam int HL  = DEB + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_up = 1'b0;
  logic btn_down = 1'b0;
  logic A;
  logic B;
  logic changed;

  int errors = 0;
  int checks = 0;

  seletor_velocidade #(.DEB_CYCLES(DEB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .A        (A),
    .B        (B),
    .changed  (changed)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit hist_up[$];
  bit hist_dn[$];
  bit deb_up, deb_dn;
  bit up_r1, up_r2, dn_r1, dn_r2;
  int model_level;
  int exp_q[$];

  task automatic model_reset();
    hist_up = {};
    hist_dn = {};
    for (int i = 0; i < HL; i++) begin
      hist_up.push_back(1'b0);
      hist_dn.push_back(1'b0);
    end
    deb_up = 0; deb_dn = 0;
    up_r1 = 0; up_r2 = 0; dn_r1 = 0; dn_r2 = 0;
    model_level = 0;
    exp_q = {};
  endtask

  // The debounced level flips when the DEB oldest entries of the last DEB+2
  // raw samples (the synchronizer delays two) all disagree with it.
  function automatic bit window_flips(bit q[$], bit lvl);
    for (int i = 0; i < DEB; i++)
      if (q[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int next_level(int lvl, int delta);
`ifdef SPEED_WRAP_EN
    return (lvl + delta + 4) % 4;
`else
    if (lvl + delta > 3) return 3;
    if (lvl + delta < 0) return 0;
    return lvl + delta;
`endif
  endfunction

  initial begin
    bit fire_up, fire_dn, rise_up, rise_dn;
    int nl;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        hist_up.push_back(btn_up);
        hist_dn.push_back(btn_down);
        if (hist_up.size() > HL) void'(hist_up.pop_front());
        if (hist_dn.size() > HL) void'(hist_dn.pop_front());
        fire_up = up_r2;
        fire_dn = dn_r2;
        up_r2 = up_r1;
        dn_r2 = dn_r1;
        rise_up = 0;
        rise_dn = 0;
        if (window_flips(hist_up, deb_up)) begin
          deb_up = !deb_up;
          rise_up = deb_up;
        end
        if (window_flips(hist_dn, deb_dn)) begin
          deb_dn = !deb_dn;
          rise_dn = deb_dn;
        end
        up_r1 = rise_up;
        dn_r1 = rise_dn;
        nl = model_level;
        if (fire_up && !fire_dn) nl = next_level(model_level, 1);
        else if (fire_dn && !fire_up) nl = next_level(model_level, -1);
        if (nl != model_level) begin
          exp_q.push_back(nl);
          model_level = nl;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic checkOutput(input string name, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  initial begin
    bit exp_chg;
    int v;
    forever begin
      @(negedge clk);
      exp_chg = (exp_q.size() != 0);
      checkOutput("changed", {2'b00, changed}, {2'b00, exp_chg});
      if (exp_chg) begin
        v = exp_q.pop_front();
        checkOutput("step_value", {1'b0, A, B}, {1'b0, v[1:0]});
      end
      checkOutput("level", {1'b0, A, B}, {1'b0, model_level[1:0]});
    end
  end

  // ---------------- stimulus ----------------
  task automatic applyStimulus(input logic up, input logic dn, input int cycles);
    btn_up = up;
    btn_down = dn;
    repeat (cycles) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkOutput("reset_immediate", {A, B, changed}, 3'b000);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic press(input logic up, input logic dn);
    applyStimulus(up, dn, 10);
    applyStimulus(1'b0, 1'b0, 10);
  endtask

  initial begin
    int mode, nb;
    logic su, sd;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    $display("[TB] single held up press");
    press(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 10);

    $display("[TB] four ups then two downs");
    doReset();
    repeat (4) press(1'b1, 1'b0);
    repeat (2) press(1'b0, 1'b1);

    $display("[TB] short bounce on up");
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(i[0] == 1'b0, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 15);

    $display("[TB] both buttons together at level 2");
    doReset();
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);

    $display("[TB] reset during an up press");
    doReset();
    press(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 4);
    doReset();
    applyStimulus(1'b1, 1'b0, 12);
    applyStimulus(1'b0, 1'b0, 10);

    $display("[TB] down at level 0");
    doReset();
    press(1'b0, 1'b1);

    $display("[TB] randomized presses");
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 3);
      su = (mode != 1);
      sd = (mode == 1) || (mode == 2);
      nb = $urandom_range(0, 3);
      for (int j = 0; j < nb; j++) begin
        applyStimulus(su, sd, $urandom_range(1, DEB - 1));
        applyStimulus(1'b0, 1'b0, $urandom_range(1, DEB - 1));
      end
      applyStimulus(su, sd, $urandom_range(DEB + 1, 12));
      applyStimulus(1'b0, 1'b0, $urandom_range(DEB + 3, 12));
      if ($urandom_range(0, 9) == 0) doReset();
    end

    applyStimulus(1'b0, 1'b0, 20);
    checkOutput("queue_drained", 3'(exp_q.size()), 3'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
